// File: rtl/led_panel_receiver_pkg.sv
// Shared definitions for the HUB75 row receiver: pin-bundle field widths,
// drain FSM encoding and the default row length.
package led_panel_receiver_pkg;

  localparam int RGB_W        = 3;
  localparam int ADDR_W       = 5;
  localparam int PIX_W        = 2 * RGB_W;
  localparam int DEFAULT_COLS = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  function automatic logic [PIX_W-1:0] pack_pixel(input logic [RGB_W-1:0] rgb0,
                                                  input logic [RGB_W-1:0] rgb1);
    return {rgb0, rgb1};
  endfunction

endpackage

// File: rtl/led_panel_receiver_sync_edge.sv
// Multi-flop synchronizer with rising-edge detect; the edge history clears on
// reset so no stale level can be reported as an edge.
module led_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // synchronizer chain and edge history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/led_panel_receiver.sv
// HUB75 panel receiver: shifts pins into a row buffer on sclk, hands complete
// rows to a drain buffer on latch and streams them out over valid/ready.
module led_panel_receiver
  import led_panel_receiver_pkg::*;
#(
  parameter int COLS        = DEFAULT_COLS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [RGB_W-1:0]          led_rgb0,
  input  logic [RGB_W-1:0]          led_rgb1,
  input  logic [ADDR_W-1:0]         led_addr,
  input  logic                      led_blank,
  input  logic                      led_latch,
  input  logic                      led_sclk,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic [$clog2(COLS)-1:0]   row_x,
  output logic [ADDR_W-1:0]         row_addr,
  output logic [RGB_W-1:0]          row_rgb0,
  output logic [RGB_W-1:0]          row_rgb1,
  output logic                      row_last,
  output logic                      len_err,
  output logic                      ovf_err,
  output logic                      blank_seen
);

  localparam int XW      = $clog2(COLS);
  localparam int CW      = XW + 1;
  localparam int DSYNC_W = 2 * RGB_W + ADDR_W + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(COLS);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [XW-1:0] X_LAST   = XW'(COLS - 1);

  logic                              sclk_rise_s;
  logic                              latch_rise_s;
  logic [SYNC_STAGES-1:0][DSYNC_W-1:0] dsync_q;
  logic [RGB_W-1:0]                  rgb0_s;
  logic [RGB_W-1:0]                  rgb1_s;
  logic [ADDR_W-1:0]                 addr_s;
  logic                              blank_s;
  logic [PIX_W-1:0]                  pixel_s;

  logic [CW-1:0]                     count_q, count_d, count_base_s;
  logic [COLS-1:0][PIX_W-1:0]        shift_buf_q;
  logic [COLS-1:0][PIX_W-1:0]        drain_buf_q;
  drain_state_e                      state_q, state_d;
  logic [XW-1:0]                     row_x_q, row_x_d, x_inc_s;
  logic [ADDR_W-1:0]                 row_addr_q, row_addr_d;
  logic [PIX_W-1:0]                  row_pix_q, row_pix_d;
  logic                              row_last_q, row_last_d;
  logic                              blank_q, blank_d;
  logic                              len_err_q, len_err_d;
  logic                              ovf_err_q, ovf_err_d;
  logic                              accept_s;

  led_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (led_sclk),
    .rise_o(sclk_rise_s)
  );

  led_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk_i (clk),
    .rst_ni(reset_n),
    .d_i   (led_latch),
    .rise_o(latch_rise_s)
  );

  // plain synchronizers for the data, address and blank pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dsync_q <= '0;
    end else begin
      dsync_q <= {dsync_q[SYNC_STAGES-2:0], led_rgb0, led_rgb1, led_addr, led_blank};
    end
  end

  assign {rgb0_s, rgb1_s, addr_s, blank_s} = dsync_q[SYNC_STAGES-1];
  assign pixel_s  = pack_pixel(rgb0_s, rgb1_s);
  assign accept_s = latch_rise_s && (count_q == CNT_FULL) && (state_q == ST_IDLE);
  assign x_inc_s  = row_x_q + XW'(1);

  // latch clears the count before a coincident shift is counted
  always_comb begin
    count_base_s = latch_rise_s ? '0 : count_q;
    if (sclk_rise_s && (count_base_s != CNT_MAX)) begin
      count_d = count_base_s + CW'(1);
    end else begin
      count_d = count_base_s;
    end
  end

  // shift buffer: newest pixel enters at the top so the first lands in column 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_buf_q <= '0;
      drain_buf_q <= '0;
      count_q     <= '0;
    end else begin
      count_q <= count_d;
      if (sclk_rise_s) begin
        shift_buf_q <= {pixel_s, shift_buf_q[COLS-1:1]};
      end
      if (accept_s) begin
        drain_buf_q <= shift_buf_q;
      end
    end
  end

  // drain FSM next state and registered row outputs
  always_comb begin
    state_d    = state_q;
    row_x_d    = row_x_q;
    row_addr_d = row_addr_q;
    row_pix_d  = row_pix_q;
    row_last_d = row_last_q;
    blank_d    = blank_q;
    len_err_d  = latch_rise_s && (count_q != CNT_FULL);
    ovf_err_d  = latch_rise_s && (state_q == ST_DRAIN);
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d    = ST_DRAIN;
          row_x_d    = '0;
          row_pix_d  = shift_buf_q[0];
          row_last_d = 1'b0;
          row_addr_d = addr_s;
          blank_d    = blank_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (row_ready && row_last_q) begin
          state_d    = ST_IDLE;
          row_x_d    = '0;
          row_last_d = 1'b0;
        end else if (row_ready) begin
          row_x_d    = x_inc_s;
          row_pix_d  = drain_buf_q[x_inc_s];
          row_last_d = (x_inc_s == X_LAST);
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // drain FSM and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      row_x_q    <= '0;
      row_addr_q <= '0;
      row_pix_q  <= '0;
      row_last_q <= 1'b0;
      blank_q    <= 1'b0;
      len_err_q  <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_x_q    <= row_x_d;
      row_addr_q <= row_addr_d;
      row_pix_q  <= row_pix_d;
      row_last_q <= row_last_d;
      blank_q    <= blank_d;
      len_err_q  <= len_err_d;
      ovf_err_q  <= ovf_err_d;
    end
  end

  assign row_valid              = (state_q == ST_DRAIN);
  assign row_x                  = row_x_q;
  assign row_addr               = row_addr_q;
  assign {row_rgb0, row_rgb1}   = row_pix_q;
  assign row_last               = row_last_q;
  assign blank_seen             = blank_q;
  assign len_err                = len_err_q;
  assign ovf_err                = ovf_err_q;

endmodule

// File: doc/led_panel_receiver.md
LED_PANEL_RECEIVER -- requirements
Module: led_panel_receiver

Interface
REQ-001 Parameters SHALL be, one per line:
  COLS, 64, shifted pixels per row (power of two, 8..128)
  SYNC_STAGES, 2, input synchronizer depth (2..3)
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; at least 4x the panel shift clock frequency
  reset_n  in  1  asynchronous, active-low reset
  led_rgb0  in  3  upper-half RGB bits (pin side)
  led_rgb1  in  3  lower-half RGB bits (pin side)
  led_addr  in  5  row address
  led_blank  in  1  blank, active high
  led_latch  in  1  latch, active high
  led_sclk  in  1  shift clock; data valid on its rising edge
  row_valid  out  1  output pixel valid
  row_ready  in  1  consumer accepts when high with row_valid
  row_x  out  log2(COLS)  column index, 0 first
  row_addr  out  5  row address of the latched row
  row_rgb0  out  3  upper-half pixel
  row_rgb1  out  3  lower-half pixel
  row_last  out  1  high on column COLS-1
  len_err  out  1  one-cycle pulse: latch seen with shift count != COLS
  ovf_err  out  1  one-cycle pulse: latch seen while draining
  blank_seen  out  1  level: led_blank value sampled at the last accepted latch

Function
REQ-003 All pin inputs SHALL pass through SYNC_STAGES flops; all decisions SHALL use synchronized values only.
REQ-004 An sclk rise (synchronized 0->1) SHALL shift the synchronized {rgb0,rgb1} into a COLS x 6-bit shift buffer; the first-shifted pixel SHALL end at column 0 and the last at COLS-1.
REQ-005 The shift count SHALL increment per sclk rise, saturate at 2*COLS-1, and clear on every latch rise.
REQ-006 A latch rise (synchronized 0->1) with count == COLS and drain FSM in IDLE SHALL copy the shift buffer into the drain buffer, capture led_addr into row_addr and led_blank into blank_seen, and enter DRAIN on the next cycle.
REQ-007 A latch rise with count != COLS SHALL pulse len_err, SHALL discard the row, and SHALL leave the drain buffer unchanged.
REQ-008 A latch rise with count == COLS while in DRAIN SHALL pulse ovf_err, SHALL discard the new row, and SHALL continue the current drain undisturbed.
REQ-009 If a latch rise has count != COLS and occurs while in DRAIN, both len_err and ovf_err SHALL pulse in the same cycle.
REQ-010 Drain FSM SHALL have two states: IDLE (row_valid=0) and DRAIN (row_valid=1).
REQ-011 In DRAIN, row_x SHALL start at 0 and advance by 1 on each row_valid&&row_ready.
REQ-012 row_x SHALL NOT wrap; acceptance at row_x=COLS-1 (row_last=1) SHALL return the FSM to IDLE.
REQ-013 row_rgb0/row_rgb1 SHALL be registered, SHALL be drain_buffer[row_x], and SHALL be stable while row_valid=1 and row_ready=0.
REQ-014 Latency SHALL be exactly 1 clk from the synchronized latch rise to row_valid=1.
REQ-015 Simultaneous sclk rise and latch rise SHALL be processed as latch first (count clear), then the shift (count=1 afterwards).
REQ-016 Shifting SHALL continue during DRAIN; the shift buffer and the drain buffer SHALL be independent.
REQ-017 led_blank SHALL NOT gate shifting or latching.

Reset
REQ-018 On reset_n=0, all of the following SHALL clear to 0: synchronizers, shift count, both buffers, row_x, row_addr, row outputs, error pulses, blank_seen; FSM SHALL go to IDLE.
REQ-019 Reset assertion mid-DRAIN SHALL drop row_valid immediately (asynchronously), with no partial completion after release.
REQ-020 The first edge after reset release SHALL NOT be detected from a stale synchronizer value; edge history SHALL reset to 0.

Structure
REQ-021 Shared package SHALL hold: HUB75 pin-bundle field widths (3/3/5), FSM state encoding (IDLE, DRAIN), and the default COLS.
REQ-022 One sub-module, led_sync_edge (synchronizer + rise detect, per signal), SHALL be used for sclk and latch; the data buses SHALL use plain synchronizers.

Verification
REQ-023 Bench SHALL cover:
  64 sclk with pixel i = {i[2:0], ~i[2:0]}, addr=5, latch; row_ready=1 -> 64 beats, row_x 0..63, row_addr=5, rgb0[x]=x[2:0], row_last at x=63.
  63 sclk then latch -> len_err pulse, no row_valid; 65 sclk then latch -> len_err pulse.
  Valid row, row_ready=0 for 10 clk, then second valid row latched -> ovf_err pulse, first row drains intact, exactly 64 beats total.
  row_ready toggling 1/0 every clk -> 64 beats, data stable during stalls, no skipped or duplicated x.
  reset_n low at beat 20 of a drain -> row_valid=0 immediately; after release no row_valid until a new valid row is latched.
  Back-to-back rows, addr 0..31, shift of row n+1 overlapping drain of row n -> 32 rows delivered in order, zero errors.
